fwd_hazard_scoreboard: RTL and testbench
========================================

Name: fwd_hazard_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the AURA16 pipeline.
- Tracks in-flight producers in a shadow shift register of DEPTH slots (slot0=EX, slot1=MEM, slot2=WB, ...).
- For each instruction in ID it decides one of two outcomes: a load-use or multi-cycle stall, or a per-operand forward source.
- Forward selects are registered and presented in the consumer's EX cycle. A saturating stall counter is included for performance monitoring.

Parameters:
- RA_W, 3, register address width.
- DEPTH, 3, tracked producer slots (min 2).
- SEL_W, $clog2(DEPTH), forward-select width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  RA_W  ID source registers
- id_uses_rs, id_uses_rt  in  1  operand actually read
- id_we  in  1  ID instruction writes a register
- id_rd  in  RA_W  ID destination
- id_rdy  in  SEL_W  first slot whose output register holds the result (ALU=1, load=2, 1..DEPTH-1)
- flush  in  1  kill ID and EX instructions
- pipe_hold  in  1  global freeze (memory wait)
- stall  out  1  hold PC/IF/ID, insert bubble into EX
- ex_fwd_a, ex_fwd_b  out  SEL_W  EX operand source: 0=register file, k=output of slot k
- stall_count  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset state: all slots invalid; ex_fwd_a/b=0; stall_count=0; stall therefore 0.
- Slot entry format: {valid, we, rd, rdy}.
- Advance: every cycle with pipe_hold=0, slot[j+1] <= slot[j] for j=0..DEPTH-2. Slot DEPTH-1 retires; the register file is write-through, so retired values are read normally.
- Issue: with pipe_hold=0, slot0 <= ID entry if id_valid & !stall & !flush; otherwise slot0 <= bubble (valid=0).
- Flush: on flush=1 with pipe_hold=0, the entry moving slot0->slot1 is loaded invalid. The ID instruction is not issued.
- Per-operand decision (combinational, ID stage):
  - An operand is ignored if it is unused or its address is 0. An ignored operand yields sel 0 and no stall.
  - Search slots 0..DEPTH-2, youngest (slot0) first. The first slot j with valid & we & rd==addr wins; later matches are ignored.
  - Winner gives p=j+1. If p < winner.rdy, the operand needs a stall. Otherwise sel=p.
  - No match gives sel=0.
- stall = id_valid & !flush & (stall_a | stall_b). stall is combinational and remains valid during pipe_hold.
- Registered selects: on advance, ex_fwd_a/b <= computed sels if the ID instruction issues, else 0. They hold during pipe_hold.
- Latency: sel is computed in ID and visible the next cycle, in EX, aligned with the consumer.
- Multi-cycle stalls: a producer with rdy=r at distance 1 stalls the consumer r-1 cycles. Re-evaluation happens each cycle as the producer moves.
- stall_count increments when stall & !pipe_hold and saturates at all-ones, with no wrap.
- Reset mid-operation clears all in-flight state on the same edge. Simultaneous reset and any other input: reset wins.

Test Plan:
- ALU back-to-back: issue rd=3, rdy=1; next cycle ID rs=3 -> stall=0; following cycle ex_fwd_a=1.
- Load-use: issue rd=2, rdy=2; next cycle ID rt=2 -> stall=1 for exactly 1 cycle, stall_count=1; consumer then issues with ex_fwd_b=2.
- Priority: ALU rd=4 issued twice back-to-back; consumer rs=4 -> ex_fwd_a=1 (youngest wins).
- Register 0 and unused operand:
  - Producer rd=0, we=1; consumer rs=0 -> stall=0, ex_fwd_a=0.
  - id_uses_rt=0 with rt matching a pending load -> no stall.
- Distance and retirement: producer rd=5, then 2 unrelated instructions, then consumer rs=5 -> ex_fwd_a=0. With 1 unrelated instruction -> ex_fwd_a=2.
- Flush, hold and reset:
  - Load rd=6 then flush with consumer rs=6 -> stall=0, count unchanged, slot1 invalid.
  - pipe_hold=1 for 3 cycles -> all state and ex_fwd frozen, count unchanged.
  - reset asserted mid-stall -> stall=0, count=0 next cycle.

Source files
------------

// File: rtl/fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_scoreboard
// Description : Forwarding and hazard unit for the AURA16 pipeline. It tracks
//               in-flight producers in a shadow shift register. For each
//               instruction in ID it decides either a stall or a per-operand
//               forward source. The forward source is registered into EX.
//               A saturating counter records hazard stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_scoreboard #(
    parameter int RA_W  = 3,
    parameter int DEPTH = 3,
    parameter int SEL_W = $clog2(DEPTH),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_we,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [SEL_W-1:0] id_rdy,
    input  logic             flush,
    input  logic             pipe_hold,
    output logic             stall,
    output logic [SEL_W-1:0] ex_fwd_a,
    output logic [SEL_W-1:0] ex_fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    // Slot DEPTH-1 only retires into the write-through register file. It is
    // never searched, so only slots 0..DEPTH-2 are stored.
    localparam int               c_NSLOT   = DEPTH - 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic             r_slot_valid [c_NSLOT];
    logic             r_slot_we    [c_NSLOT];
    logic [RA_W-1:0]  r_slot_rd    [c_NSLOT];
    logic [SEL_W-1:0] r_slot_rdy   [c_NSLOT];
    logic [SEL_W-1:0] r_fwd_a;
    logic [SEL_W-1:0] r_fwd_b;
    logic [CNT_W-1:0] r_stall_count;

    logic             w_use_a;
    logic             w_use_b;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] w_sel_b;
    logic             w_stall_a;
    logic             w_stall_b;
    logic             w_stall;
    logic             w_issue;

    assign w_use_a = id_uses_rs && (id_rs != '0);
    assign w_use_b = id_uses_rt && (id_rt != '0);

    // Per-operand search. The scan runs oldest to youngest so that the
    // youngest match overrides older ones.
    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_stall_a = 1'b0;
        w_stall_b = 1'b0;
        for (int j = c_NSLOT - 1; j >= 0; j--) begin
            if (w_use_a && r_slot_valid[j] && r_slot_we[j] && (r_slot_rd[j] == id_rs)) begin
                w_sel_a   = SEL_W'(j + 1);
                w_stall_a = (SEL_W'(j + 1) < r_slot_rdy[j]);
            end
            if (w_use_b && r_slot_valid[j] && r_slot_we[j] && (r_slot_rd[j] == id_rt)) begin
                w_sel_b   = SEL_W'(j + 1);
                w_stall_b = (SEL_W'(j + 1) < r_slot_rdy[j]);
            end
        end
    end

    assign w_stall = id_valid && !flush && (w_stall_a || w_stall_b);
    assign w_issue = id_valid && !flush && !w_stall;

    // Producer shift register. Slot 0 takes the issuing ID instruction or a
    // bubble. A flush kills the EX-stage entry as it moves into slot 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < c_NSLOT; j++) begin
                r_slot_valid[j] <= 1'b0;
                r_slot_we[j]    <= 1'b0;
                r_slot_rd[j]    <= '0;
                r_slot_rdy[j]   <= '0;
            end
        end else if (!pipe_hold) begin
            r_slot_valid[0] <= w_issue;
            r_slot_we[0]    <= id_we;
            r_slot_rd[0]    <= id_rd;
            r_slot_rdy[0]   <= id_rdy;
            for (int j = 1; j < c_NSLOT; j++) begin
                r_slot_valid[j] <= r_slot_valid[j-1] && !(flush && (j == 1));
                r_slot_we[j]    <= r_slot_we[j-1];
                r_slot_rd[j]    <= r_slot_rd[j-1];
                r_slot_rdy[j]   <= r_slot_rdy[j-1];
            end
        end
    end

    // The forward selects enter EX with the consumer. Any non-issue cycle
    // clears them to register-file reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd_a <= '0;
            r_fwd_b <= '0;
        end else if (!pipe_hold) begin
            r_fwd_a <= w_issue ? w_sel_a : '0;
            r_fwd_b <= w_issue ? w_sel_b : '0;
        end
    end

    // Saturating hazard-stall counter. Frozen pipeline cycles are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && !pipe_hold && (r_stall_count != c_CNT_MAX)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall       = w_stall;
    assign ex_fwd_a    = r_fwd_a;
    assign ex_fwd_b    = r_fwd_b;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_scoreboard
// Description : Directed vector bench for fwd_hazard_scoreboard (DEPTH=3,
//               narrow counter so that saturation is reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_scoreboard;

    localparam int RA_W  = 3;
    localparam int DEPTH = 3;
    localparam int SEL_W = 2;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_we;
    logic [RA_W-1:0]  id_rd;
    logic [SEL_W-1:0] id_rdy;
    logic             flush;
    logic             pipe_hold;
    logic             stall;
    logic [SEL_W-1:0] ex_fwd_a;
    logic [SEL_W-1:0] ex_fwd_b;
    logic [CNT_W-1:0] stall_count;

    int checks   = 0;
    int failures = 0;

    fwd_hazard_scoreboard #(
        .RA_W (RA_W),
        .DEPTH(DEPTH),
        .SEL_W(SEL_W),
        .CNT_W(CNT_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .id_we      (id_we),
        .id_rd      (id_rd),
        .id_rdy     (id_rdy),
        .flush      (flush),
        .pipe_hold  (pipe_hold),
        .stall      (stall),
        .ex_fwd_a   (ex_fwd_a),
        .ex_fwd_b   (ex_fwd_b),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             v;
        logic [RA_W-1:0]  rs;
        logic             urs;
        logic [RA_W-1:0]  rt;
        logic             urt;
        logic             we;
        logic [RA_W-1:0]  rd;
        logic [SEL_W-1:0] rdy;
        logic             fl;
        logic             hold;
        logic             e_stall;
        logic [SEL_W-1:0] e_fa;
        logic [SEL_W-1:0] e_fb;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic v, input logic [RA_W-1:0] rs,
                       input logic urs, input logic [RA_W-1:0] rt, input logic urt,
                       input logic we, input logic [RA_W-1:0] rd,
                       input logic [SEL_W-1:0] rdy, input logic fl, input logic hold,
                       input logic e_stall, input logic [SEL_W-1:0] e_fa,
                       input logic [SEL_W-1:0] e_fb, input logic [CNT_W-1:0] e_cnt);
        vec_t t;
        t.rst = rst;  t.v = v;    t.rs = rs;   t.urs = urs;
        t.rt = rt;    t.urt = urt; t.we = we;  t.rd = rd;
        t.rdy = rdy;  t.fl = fl;  t.hold = hold;
        t.e_stall = e_stall; t.e_fa = e_fa; t.e_fb = e_fb; t.e_cnt = e_cnt;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0d required=%0d", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        reset      = t.rst;
        id_valid   = t.v;
        id_rs      = t.rs;
        id_uses_rs = t.urs;
        id_rt      = t.rt;
        id_uses_rt = t.urt;
        id_we      = t.we;
        id_rd      = t.rd;
        id_rdy     = t.rdy;
        flush      = t.fl;
        pipe_hold  = t.hold;
    endtask

    initial begin
        vec_t t;
        logic [CNT_W-1:0] exp_cnt;

        reset = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_we = 1'b0; id_rd = '0;
        id_rdy = '0; flush = 1'b0; pipe_hold = 1'b0;

        //  rst v rs urs rt urt we rd rdy fl hold | stall fa fb cnt
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // 0 reset
        add(0, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0,   0, 0, 0, 0);  // 1 ALU rd3
        add(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);  // 2 rs3 -> fwd 1
        add(0, 1, 0, 0, 0, 0, 1, 2, 2, 0, 0,   0, 0, 0, 0);  // 3 load rd2
        add(0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0,   1, 0, 0, 1);  // 4 load-use stall
        add(0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0,   0, 0, 2, 1);  // 5 issues, fwd_b 2
        add(0, 1, 0, 0, 0, 0, 1, 4, 1, 0, 0,   0, 0, 0, 1);  // 6 ALU rd4 (old)
        add(0, 1, 0, 0, 0, 0, 1, 4, 1, 0, 0,   0, 0, 0, 1);  // 7 ALU rd4 (young)
        add(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1);  // 8 youngest wins
        add(0, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0,   0, 0, 0, 1);  // 9 load rd0
        add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);  // 10 rs0 ignored
        add(0, 1, 0, 0, 0, 0, 1, 1, 2, 0, 0,   0, 0, 0, 1);  // 11 load rd1
        add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);  // 12 rt1 unused
        add(0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0,   0, 0, 0, 1);  // 13 ALU rd5
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);  // 14 unrelated
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);  // 15 unrelated
        add(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);  // 16 retired -> 0
        add(0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0,   0, 0, 0, 1);  // 17 ALU rd5
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);  // 18 unrelated
        add(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,   0, 2, 0, 1);  // 19 distance 2
        add(0, 1, 0, 0, 0, 0, 1, 6, 2, 0, 0,   0, 0, 0, 1);  // 20 load rd6
        add(0, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1);  // 21 flush
        add(0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);  // 22 slot1 killed
        add(0, 1, 0, 0, 0, 0, 1, 7, 2, 0, 0,   0, 0, 0, 1);  // 23 load rd7
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 1);  // 24 hold, stall held
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 1);  // 25
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 1);  // 26
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 2);  // 27 released
        add(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0,   0, 2, 0, 2);  // 28 fwd 2
        add(0, 1, 0, 0, 0, 0, 1, 3, 1, 0, 1,   0, 2, 0, 2);  // 29 hold keeps fwd
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 2, 0, 2);  // 30
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2);  // 31 bubble
        add(0, 1, 0, 0, 0, 0, 1, 2, 2, 0, 0,   0, 0, 0, 2);  // 32 load rd2
        add(0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0,   1, 0, 0, 3);  // 33 stall
        add(0, 1, 0, 0, 0, 0, 1, 4, 2, 0, 0,   0, 0, 0, 3);  // 34 load rd4
        add(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0);  // 35 reset mid-stall
        add(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // 36 state cleared

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            @(negedge clk);
            drive(t);
            #1;
            chk("stall", i, 16'(stall), 16'(t.e_stall));
            @(posedge clk);
            #1;
            chk("ex_fwd_a", i, 16'(ex_fwd_a), 16'(t.e_fa));
            chk("ex_fwd_b", i, 16'(ex_fwd_b), 16'(t.e_fb));
            chk("stall_count", i, 16'(stall_count), 16'(t.e_cnt));
        end

        // Counter saturation: repeated load/use pairs, one stall each.
        exp_cnt = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            reset = 1'b0; flush = 1'b0; pipe_hold = 1'b0;
            id_valid = 1'b1; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
            id_rs = '0; id_rt = '0; id_we = 1'b1; id_rd = 3'd1; id_rdy = 2'd2;
            @(negedge clk);
            id_we = 1'b0; id_rd = '0; id_rdy = '0;
            id_rt = 3'd1; id_uses_rt = 1'b1;
            #1;
            chk("sat_stall", 100 + k, 16'(stall), 16'd1);
            @(posedge clk);
            #1;
            exp_cnt = (exp_cnt == 3'd7) ? 3'd7 : exp_cnt + 3'd1;
            chk("sat_count", 100 + k, 16'(stall_count), 16'(exp_cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
